mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares Genie's single external memory port (rvalid/rready/raddr/rdata plus wvalid/wready/waddr/wdata) among NREQ requesters: layer data loaders, prefetchers and the instruction-side debug dump. It sits between the requesters and the top-level memory pins and replaces the static layer_type mux. The grant is held for a bounded burst so one loader cannot starve the others. Responses route zero-latency to the granted requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 16, completed transfers per grant before forced release; 0 = unlimited
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_rvalid  in  NREQ  per-requester read request, held until acknowledged
- req_raddr  in  26*NREQ  read address, requester i at [26*i+25:26*i]
- req_rready  out  NREQ  read acknowledge/data-valid to requester
- req_rdata  out  32  read data, shared; valid only with the matching req_rready bit
- req_wvalid  in  NREQ  per-requester write request, held until acknowledged
- req_waddr  in  26*NREQ  write address
- req_wdata  in  32*NREQ  write data
- req_wready  out  NREQ  write acknowledge
- rvalid/raddr  out  1/26  read request to memory
- rready/rdata  in  1/32  memory read acknowledge with data
- wvalid/waddr/wdata  out  1/26/32  write request to memory
- wready  in  1  memory write acknowledge
- gnt  out  NREQ  one-hot current grant; all-zero when idle
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Registers: gnt (one-hot), ptr (index, clog2(NREQ) bits), bcnt (clog2(MAX_BURST+1) bits).
- Pending vector p = req_rvalid | req_wvalid.
- IDLE: if p != 0, select the first set bit of p searching from ptr upward with wrap; load gnt, clear bcnt, go GRANT. Otherwise stay.
- GRANT, granted index g: rvalid = req_rvalid[g], raddr = slice g, wvalid = req_wvalid[g], waddr/wdata = slice g. When not granted, all memory-side outputs are 0.
- req_rready[g] = rready, req_wready[g] = wready, req_rdata = rdata while granted. All other bits 0; req_rdata is 0 when idle.
- Read and write from the granted requester may run concurrently. A cycle with rvalid&rready, wvalid&wready, or both counts as one completion.
- Release, go IDLE, ptr = (g+1) mod NREQ:
  - (a) p[g] == 0 in a GRANT cycle;
  - (b) MAX_BURST != 0 and a completion makes bcnt reach MAX_BURST.
- A grant never changes while the granted requester's valid is high without a completion in that cycle.
- Memory-side rready/wready arriving with no matching valid are ignored and are not counted.

## Timing
- All outputs reset to 0: gnt, busy, rvalid, wvalid, addresses, wdata, req_rready, req_wready, req_rdata. State resets to IDLE, ptr to 0, bcnt to 0.
- Reset is asynchronous and may occur mid-transfer. Outputs drop immediately, and requesters must re-request.
- Grant latency: request seen in IDLE at edge N, gnt/busy high after edge N+1, memory-side valid visible in that same cycle.
- Data/ack path is purely combinational, with 0-cycle latency from memory to requester.
- Each release inserts exactly one IDLE cycle before the next grant.
- Burst expiry on the same cycle the requester drops valid is treated as one release; ptr advances once.
- NREQ requesters all pending with MAX_BURST = B: each receives B transfers in turn, order g, g+1, … with wrap.

## Configuration
- GENIE_ARB_FIXED_PRI_EN defined: IDLE selection is fixed priority, with the lowest index winning. ptr is not implemented and the release rules are unchanged, so MAX_BURST still bounds hold time.
- Undefined (default): round-robin from ptr as above.

## Test plan
- Single read: req_rvalid[2]=1, raddr2=0x0001234 after reset → gnt=4'b0100 one cycle later, raddr=0x0001234. Memory rready with rdata=0xDEADBEEF → req_rready=4'b0100, req_rdata=0xDEADBEEF same cycle.
- Round-robin: all four hold rvalid, MAX_BURST=2, memory acks every cycle → grant order 0,1,2,3,0, two acks each, one idle cycle between grants.
- Early release: requester 1 drops valid after 3 writes (MAX_BURST=16) → IDLE next cycle, ptr=2, and pending requester 3 is granted before requester 0.
- Concurrent R/W: granted requester asserts rvalid and wvalid, memory acks both in one cycle → both acks routed, bcnt increments by 1.
- Stall: wready held low 10 cycles with other requesters pending → gnt stable, wvalid stays high, no release.
- Async reset mid-burst: rst_n low mid-cycle → all outputs 0 before next edge; after release, ptr=0 and requester 0 wins first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory read/write port among NREQ requesters.
// Define GENIE_ARB_FIXED_PRI_EN to select fixed lowest-index-wins priority instead of round-robin.
module mem_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_rvalid,
    input  logic [26*NREQ-1:0]   req_raddr,
    output logic [NREQ-1:0]      req_rready,
    output logic [31:0]          req_rdata,
    input  logic [NREQ-1:0]      req_wvalid,
    input  logic [26*NREQ-1:0]   req_waddr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_wready,
    output logic                 rvalid,
    output logic [25:0]          raddr,
    input  logic                 rready,
    input  logic [31:0]          rdata,
    output logic                 wvalid,
    output logic [25:0]          waddr,
    output logic [31:0]          wdata,
    input  logic                 wready,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy
);
    localparam int PW      = $clog2(NREQ);
    localparam int BW      = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int BLAST_I = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;
    localparam logic [BW-1:0] BLAST = BLAST_I[BW-1:0];

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [BW-1:0]   bcnt, bcnt_nxt;
    logic [NREQ-1:0] pend;
    logic [PW-1:0]   g_idx, sel_idx, base, cand;
    logic [PW:0]     sum;
    logic            completion, burst_done, rel;

    assign pend       = req_rvalid | req_wvalid;
    assign completion = (rvalid & rready) | (wvalid & wready);
    assign burst_done = (MAX_BURST != 0) && completion && (bcnt == BLAST);
    assign rel        = (state == GRANT) && (!pend[g_idx] || burst_done);
    assign busy       = (state == GRANT);

`ifdef GENIE_ARB_FIXED_PRI_EN
    assign base = '0;
`else
    logic [PW-1:0] ptr, next_g;

    assign base   = ptr;
    assign next_g = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (rel)
            ptr <= next_g;
    end
`endif

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i])
                g_idx = PW'(i);
    end

    // Walk downward so the candidate closest to base (after wrap) is the one that sticks.
    always_comb begin
        sel_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, base} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            cand = sum[PW-1:0];
            if (pend[cand])
                sel_idx = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                if (|pend) begin
                    state_nxt        = GRANT;
                    gnt_nxt          = '0;
                    gnt_nxt[sel_idx] = 1'b1;
                    bcnt_nxt         = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    bcnt_nxt  = '0;
                end else if (completion && (MAX_BURST != 0)) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                bcnt_nxt  = '0;
            end
        endcase
    end

    // Everything below is zero-latency routing keyed off the registered one-hot grant.
    always_comb begin
        rvalid     = 1'b0;
        raddr      = '0;
        wvalid     = 1'b0;
        waddr      = '0;
        wdata      = '0;
        req_rready = '0;
        req_wready = '0;
        req_rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                rvalid        = req_rvalid[i];
                raddr         = req_raddr[26*i +: 26];
                wvalid        = req_wvalid[i];
                waddr         = req_waddr[26*i +: 26];
                wdata         = req_wdata[32*i +: 32];
                req_rready[i] = rready;
                req_wready[i] = wready;
                req_rdata     = rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MAX_BURST=16, instance b uses MAX_BURST=2.
module tb_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_rvalid, req_wvalid;
    logic [103:0] req_raddr, req_waddr;
    logic [127:0] req_wdata;
    logic         rready, wready;
    logic [31:0]  rdata;

    logic [3:0]  a_req_rready, a_req_wready, a_gnt;
    logic [31:0] a_req_rdata, a_wdata;
    logic        a_rvalid, a_wvalid, a_busy;
    logic [25:0] a_raddr, a_waddr;

    logic [3:0]  b_req_rready, b_req_wready, b_gnt;
    logic [31:0] b_req_rdata, b_wdata;
    logic        b_rvalid, b_wvalid, b_busy;
    logic [25:0] b_raddr, b_waddr;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] rr_exp [14] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                4'b0001, 4'b0001};

    always #5 clk = ~clk;

    mem_arbiter #(.NREQ(4), .MAX_BURST(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(a_req_rready),
        .req_rdata(a_req_rdata), .req_wvalid(req_wvalid), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_wready(a_req_wready),
        .rvalid(a_rvalid), .raddr(a_raddr), .rready(rready), .rdata(rdata),
        .wvalid(a_wvalid), .waddr(a_waddr), .wdata(a_wdata), .wready(wready),
        .gnt(a_gnt), .busy(a_busy)
    );

    mem_arbiter #(.NREQ(4), .MAX_BURST(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(b_req_rready),
        .req_rdata(b_req_rdata), .req_wvalid(req_wvalid), .req_waddr(req_waddr),
        .req_wdata(req_wdata), .req_wready(b_req_wready),
        .rvalid(b_rvalid), .raddr(b_raddr), .rready(rready), .rdata(rdata),
        .wvalid(b_wvalid), .waddr(b_waddr), .wdata(b_wdata), .wready(wready),
        .gnt(b_gnt), .busy(b_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rv, input logic [3:0] wv,
                                 input logic rr, input logic wr);
        req_rvalid = rv;
        req_wvalid = wv;
        rready     = rr;
        wready     = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_raddr = '0;
        req_waddr = '0;
        req_wdata = '0;
        rdata     = 32'hFFFF_FFFF;
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1);
        #2;
        checkOutput("reset_gnt", {28'd0, a_gnt}, 32'd0);
        checkOutput("reset_busy", {31'd0, a_busy}, 32'd0);
        checkOutput("reset_rvalid", {31'd0, a_rvalid}, 32'd0);
        checkOutput("reset_req_rready", {28'd0, a_req_rready}, 32'd0);
        checkOutput("reset_req_rdata", a_req_rdata, 32'd0);
        checkOutput("reset_b_gnt", {28'd0, b_gnt}, 32'd0);
        tick();
        tick();

        // Single read from requester 2.
        rst_n = 1'b1;
        rdata = 32'd0;
        req_raddr[26*2 +: 26] = 26'h0001234;
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("single_pre_gnt", {28'd0, a_gnt}, 32'd0);
        tick();
        checkOutput("single_gnt", {28'd0, a_gnt}, 32'h4);
        checkOutput("single_busy", {31'd0, a_busy}, 32'd1);
        checkOutput("single_rvalid", {31'd0, a_rvalid}, 32'd1);
        checkOutput("single_raddr", {6'd0, a_raddr}, 32'h0001234);
        rready = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        #1;
        checkOutput("single_req_rready", {28'd0, a_req_rready}, 32'h4);
        checkOutput("single_req_rdata", a_req_rdata, 32'hDEAD_BEEF);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("single_drop_rvalid", {31'd0, a_rvalid}, 32'd0);
        checkOutput("single_drop_gnt", {28'd0, a_gnt}, 32'h4);
        tick();
        checkOutput("single_release_gnt", {28'd0, a_gnt}, 32'd0);
        checkOutput("single_release_busy", {31'd0, a_busy}, 32'd0);

        // Requester 1 writes three times then drops; ptr moves to 2 so 3 beats 0.
        req_waddr[26*1 +: 26] = 26'h0000ABC;
        req_wdata[32*1 +: 32] = 32'h1111_2222;
        applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1);
        tick();
        checkOutput("early_gnt", {28'd0, a_gnt}, 32'h2);
        checkOutput("early_wvalid", {31'd0, a_wvalid}, 32'd1);
        checkOutput("early_waddr", {6'd0, a_waddr}, 32'h0000ABC);
        checkOutput("early_wdata", a_wdata, 32'h1111_2222);
        checkOutput("early_req_wready", {28'd0, a_req_wready}, 32'h2);
        req_rvalid = 4'b1001;
        tick();
        checkOutput("early_hold_gnt", {28'd0, a_gnt}, 32'h2);
        tick();
        tick();
        applyStimulus(4'b1001, 4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("early_drop_gnt", {28'd0, a_gnt}, 32'h2);
        tick();
        checkOutput("early_idle_gnt", {28'd0, a_gnt}, 32'd0);
        checkOutput("early_idle_busy", {31'd0, a_busy}, 32'd0);
        tick();
        checkOutput("early_next_gnt", {28'd0, a_gnt}, 32'h8);

        // Requester 3 write stalls with requester 0 waiting.
        req_waddr[26*3 +: 26] = 26'h3FF_FFFF;
        req_wdata[32*3 +: 32] = 32'hCAFE_F00D;
        applyStimulus(4'b1001, 4'b1000, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("stall_gnt", {28'd0, a_gnt}, 32'h8);
            checkOutput("stall_wvalid", {31'd0, a_wvalid}, 32'd1);
        end
        checkOutput("stall_waddr", {6'd0, a_waddr}, 32'h3FF_FFFF);

        // Asynchronous reset in the middle of the stalled burst.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_gnt", {28'd0, a_gnt}, 32'd0);
        checkOutput("areset_busy", {31'd0, a_busy}, 32'd0);
        checkOutput("areset_rvalid", {31'd0, a_rvalid}, 32'd0);
        checkOutput("areset_wvalid", {31'd0, a_wvalid}, 32'd0);
        checkOutput("areset_waddr", {6'd0, a_waddr}, 32'd0);
        checkOutput("areset_wdata", a_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("areset_first_gnt", {28'd0, a_gnt}, 32'h1);

        // Round-robin with burst of two on instance b, all four requesters reading.
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        rdata = 32'h55AA_55AA;
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick();
            checkOutput("rr_gnt", {28'd0, b_gnt}, {28'd0, rr_exp[k]});
            checkOutput("rr_req_rready", {28'd0, b_req_rready}, {28'd0, rr_exp[k]});
            if (k == 0)
                checkOutput("rr_req_rdata", b_req_rdata, 32'h55AA_55AA);
        end

        // Concurrent read and write acknowledged together count as one completion.
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b1);
        tick();
        checkOutput("rw_gnt", {28'd0, b_gnt}, 32'h1);
        checkOutput("rw_req_rready", {28'd0, b_req_rready}, 32'h1);
        checkOutput("rw_req_wready", {28'd0, b_req_wready}, 32'h1);
        tick();
        checkOutput("rw_hold_gnt", {28'd0, b_gnt}, 32'h1);
        tick();
        checkOutput("rw_release_gnt", {28'd0, b_gnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
